// File: rtl/tx_link_ctrl.sv
// Transmit link-layer controller: training, idle fill, packet framing and periodic SKP insertion.
// States: TRAIN ordered sets | IDLE fill | STP start-of-packet | DATA payload/PAD | END end-of-packet | SKP clock-comp set
module tx_link_ctrl #(
  parameter int TS_COUNT     = 8,
  parameter int SKP_INTERVAL = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       retrain,
  input  logic       pkt_req,
  output logic       pkt_gnt,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] tx_byte,
  output logic       tx_k,
  output logic       link_up
);

  localparam int TSW = (TS_COUNT > 1) ? $clog2(TS_COUNT) : 1;
  localparam int SKW = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;

  localparam logic [7:0] SYM_COM  = 8'hBC;
  localparam logic [7:0] SYM_TS   = 8'h4A;
  localparam logic [7:0] SYM_IDLE = 8'h00;
  localparam logic [7:0] SYM_STP  = 8'hFB;
  localparam logic [7:0] SYM_PAD  = 8'hF7;
  localparam logic [7:0] SYM_END  = 8'hFD;
  localparam logic [7:0] SYM_SKP  = 8'h1C;

  typedef enum logic [2:0] {
    ST_TRAIN,
    ST_IDLE,
    ST_STP,
    ST_DATA,
    ST_END,
    ST_SKP
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sym_cnt_q, sym_cnt_d;
  logic [TSW-1:0]   ts_cnt_q, ts_cnt_d;
  logic [SKW-1:0]   skp_cnt_q, skp_cnt_d;
  logic             skp_pending_q, skp_pending_d;
  logic             link_up_q, link_up_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             tx_k_q, tx_k_d;
  logic             pkt_gnt_q, pkt_gnt_d;
  logic             skp_wrap;
  logic             skp_clr;

  always_comb begin
    state_d       = state_q;
    sym_cnt_d     = sym_cnt_q;
    ts_cnt_d      = ts_cnt_q;
    skp_cnt_d     = skp_cnt_q;
    skp_pending_d = skp_pending_q;
    link_up_d     = link_up_q;
    tx_byte_d     = tx_byte_q;
    tx_k_d        = tx_k_q;
    pkt_gnt_d     = 1'b0;
    skp_wrap      = 1'b0;
    skp_clr       = 1'b0;

    if (enb && retrain) begin
      state_d       = ST_TRAIN;
      sym_cnt_d     = '0;
      ts_cnt_d      = '0;
      skp_cnt_d     = '0;
      skp_pending_d = 1'b0;
      link_up_d     = 1'b0;
      tx_byte_d     = SYM_IDLE;
      tx_k_d        = 1'b0;
    end else if (enb) begin
      if (link_up_q) begin
        skp_wrap  = (skp_cnt_q == SKW'(SKP_INTERVAL - 1));
        skp_cnt_d = skp_wrap ? '0 : skp_cnt_q + SKW'(1);
      end

      case (state_q)
        ST_TRAIN: begin
          tx_byte_d = (sym_cnt_q == 2'd0) ? SYM_COM : SYM_TS;
          tx_k_d    = (sym_cnt_q == 2'd0);
          sym_cnt_d = sym_cnt_q + 2'd1;
          if (sym_cnt_q == 2'd3) begin
            if (ts_cnt_q == TSW'(TS_COUNT - 1)) begin
              ts_cnt_d  = '0;
              state_d   = ST_IDLE;
              link_up_d = 1'b1;
            end else begin
              ts_cnt_d = ts_cnt_q + TSW'(1);
            end
          end
        end
        ST_IDLE: begin
          tx_byte_d = SYM_IDLE;
          tx_k_d    = 1'b0;
          if (skp_pending_q)  state_d = ST_SKP;
          else if (pkt_req)   state_d = ST_STP;
        end
        ST_STP: begin
          tx_byte_d = SYM_STP;
          tx_k_d    = 1'b1;
          pkt_gnt_d = 1'b1;
          state_d   = ST_DATA;
        end
        ST_DATA: begin
          if (in_valid) begin
            tx_byte_d = in_byte;
            tx_k_d    = 1'b0;
            if (in_last) state_d = ST_END;
          end else begin
            tx_byte_d = SYM_PAD;
            tx_k_d    = 1'b1;
          end
        end
        ST_END: begin
          tx_byte_d = SYM_END;
          tx_k_d    = 1'b1;
          state_d   = skp_pending_q ? ST_SKP : ST_IDLE;
        end
        ST_SKP: begin
          tx_byte_d = (sym_cnt_q == 2'd0) ? SYM_COM : SYM_SKP;
          tx_k_d    = 1'b1;
          skp_clr   = (sym_cnt_q == 2'd0);
          sym_cnt_d = sym_cnt_q + 2'd1;
          if (sym_cnt_q == 2'd3) begin
            sym_cnt_d = '0;
            state_d   = ST_IDLE;
          end
        end
        default: state_d = ST_TRAIN;
      endcase

      // A fresh wrap on the same cycle as the SKP start re-arms the request.
      skp_pending_d = (skp_pending_q & ~skp_clr) | skp_wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_TRAIN;
      sym_cnt_q     <= '0;
      ts_cnt_q      <= '0;
      skp_cnt_q     <= '0;
      skp_pending_q <= 1'b0;
      link_up_q     <= 1'b0;
      tx_byte_q     <= 8'h00;
      tx_k_q        <= 1'b0;
      pkt_gnt_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sym_cnt_q     <= sym_cnt_d;
      ts_cnt_q      <= ts_cnt_d;
      skp_cnt_q     <= skp_cnt_d;
      skp_pending_q <= skp_pending_d;
      link_up_q     <= link_up_d;
      tx_byte_q     <= tx_byte_d;
      tx_k_q        <= tx_k_d;
      pkt_gnt_q     <= pkt_gnt_d;
    end
  end

  assign pkt_gnt  = pkt_gnt_q & enb;
  assign in_ready = (state_q == ST_DATA);
  assign tx_byte  = tx_byte_q;
  assign tx_k     = tx_k_q;
  assign link_up  = link_up_q;

endmodule

// File: tb/tb_tx_link_ctrl.sv
// Randomized bench for tx_link_ctrl against a symbol-queue reference model.
module tb_tx_link_ctrl;

  localparam int TS  = 8;
  localparam int SKI = 64;
  localparam int NCYC = 6000;

  localparam int KIND_PLAIN     = 0;
  localparam int KIND_TRAIN_END = 1;
  localparam int KIND_SKP_FIRST = 2;
  localparam int KIND_STP       = 3;
  localparam int KIND_END       = 4;

  logic       clk = 1'b0;
  logic       rst, enb, retrain, pkt_req, in_valid, in_last;
  logic [7:0] in_byte;
  logic       pkt_gnt, in_ready, tx_k, link_up;
  logic [7:0] tx_byte;

  tx_link_ctrl #(.TS_COUNT(TS), .SKP_INTERVAL(SKI)) dut (
    .clk      (clk),
    .rst      (rst),
    .enb      (enb),
    .retrain  (retrain),
    .pkt_req  (pkt_req),
    .pkt_gnt  (pkt_gnt),
    .in_byte  (in_byte),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .tx_byte  (tx_byte),
    .tx_k     (tx_k),
    .link_up  (link_up)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: committed symbol bursts sit in a queue; DATA and IDLE fill in when it is empty.
  typedef struct {
    logic [7:0] b;
    logic       k;
    int         kind;
  } sym_t;

  sym_t       sq[$];
  bit         m_link, m_pkt, m_gnt, m_pend, m_acc;
  int         m_cnt;
  logic [7:0] m_byte;
  logic       m_k;

  function automatic void push(logic [7:0] b, logic k, int kind);
    sym_t s;
    s.b = b; s.k = k; s.kind = kind;
    sq.push_back(s);
  endfunction

  function automatic void push_skp();
    push(8'hBC, 1'b1, KIND_SKP_FIRST);
    for (int i = 0; i < 3; i++) push(8'h1C, 1'b1, KIND_PLAIN);
  endfunction

  function automatic void m_restart();
    sq.delete();
    for (int i = 0; i < TS; i++)
      for (int j = 0; j < 4; j++)
        push((j == 0) ? 8'hBC : 8'h4A, (j == 0),
             (i == TS - 1 && j == 3) ? KIND_TRAIN_END : KIND_PLAIN);
    m_link = 0; m_pkt = 0; m_gnt = 0; m_pend = 0; m_cnt = 0;
    m_byte = 8'h00; m_k = 1'b0;
  endfunction

  function automatic void model_edge();
    sym_t s;
    bit   wrap, clr, old_pend;
    m_acc = 0;
    if (!rst) begin m_restart(); return; end
    if (!enb) begin m_gnt = 0; return; end
    if (retrain) begin m_restart(); return; end
    wrap = m_link && (m_cnt == SKI - 1);
    clr = 0;
    old_pend = m_pend;
    m_gnt = 0;
    if (m_link) m_cnt = wrap ? 0 : m_cnt + 1;
    if (sq.size() > 0) begin
      s = sq.pop_front();
      m_byte = s.b; m_k = s.k;
      case (s.kind)
        KIND_TRAIN_END: m_link = 1;
        KIND_SKP_FIRST: clr = 1;
        KIND_STP:       begin m_gnt = 1; m_pkt = 1; end
        KIND_END:       if (old_pend) push_skp();
        default: ;
      endcase
    end else if (m_pkt) begin
      if (in_valid) begin
        m_byte = in_byte; m_k = 1'b0; m_acc = 1;
        if (in_last) begin m_pkt = 0; push(8'hFD, 1'b1, KIND_END); end
      end else begin
        m_byte = 8'hF7; m_k = 1'b1;
      end
    end else begin
      m_byte = 8'h00; m_k = 1'b0;
      if (old_pend) push_skp();
      else if (pkt_req) push(8'hFB, 1'b1, KIND_STP);
    end
    m_pend = (m_pend && !clr) || wrap;
  endfunction

  int         src_len, src_idx;
  logic [7:0] src_seed;

  initial begin
    rst = 1'b0; enb = 1'b1; retrain = 1'b0; pkt_req = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_byte = 8'h00;
    src_len = 0; src_idx = 0; src_seed = 8'h11;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      model_edge();
      #1;
      check("tx_byte",  32'(tx_byte),  32'(m_byte));
      check("tx_k",     32'(tx_k),     32'(m_k));
      check("link_up",  32'(link_up),  32'(m_link));
      check("in_ready", 32'(in_ready), 32'(m_pkt));
      check("pkt_gnt",  32'(pkt_gnt),  32'(m_gnt && enb));

      if (!rst || (enb && retrain)) begin
        src_len = 0; src_idx = 0;
      end
      if (m_acc) src_idx++;
      if (m_gnt) begin
        pkt_req = 1'b0;
        src_len = ($urandom_range(0, 9) == 0) ? 100 : $urandom_range(1, 8);
        src_idx = 0;
        src_seed = 8'($urandom);
      end
      if (!pkt_req && !m_pkt && $urandom_range(0, 3) == 0) pkt_req = 1'b1;

      if (m_pkt && src_idx < src_len) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_byte  = src_seed + 8'(src_idx * 37);
        in_last  = (src_idx == src_len - 1);
      end else begin
        in_valid = 1'($urandom);
        in_byte  = 8'($urandom);
        in_last  = 1'($urandom);
      end

      rst     = (cyc < 2) ? 1'b0 : ($urandom_range(0, 1499) != 0);
      enb     = ($urandom_range(0, 7) != 0);
      retrain = m_pkt ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 399) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
